// File: rtl/cache_tag_array_pkg.sv
// Shared operation/state types and geometry helpers for the L1 tag store.
package cache_tag_array_pkg;

  typedef enum logic [1:0] {
    CACHE_LOOKUP = 2'd0,
    CACHE_FILL   = 2'd1,
    CACHE_INVAL  = 2'd2,
    CACHE_RSVD   = 2'd3
  } cache_op_e;

  typedef enum logic [1:0] {
    TAG_ST_INIT  = 2'd0,
    TAG_ST_IDLE  = 2'd1,
    TAG_ST_FLUSH = 2'd2
  } tag_state_e;

  function automatic int BASIC_TAG_WIDTH(input int max_mem, input int width_e, input int deep_e);
    return max_mem - width_e - deep_e;
  endfunction

  function automatic int CACHE_SETS(input int deep_e);
    return 32'sd1 << deep_e;
  endfunction

  function automatic int WAY_WIDTH(input int ways);
    return (ways > 32'sd1) ? $clog2(ways) : 32'sd1;
  endfunction

endpackage

// File: rtl/cache_tag_array_if.sv
// Request/response and flush-control bundle between the core front end and the tag store.
interface cache_tag_array_if #(
  parameter int MAX_MEM = 32,
  parameter int TAG_W   = 20,
  parameter int WAYW    = 1
) ();
  import cache_tag_array_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [MAX_MEM-1:0] req_addr;
  cache_op_e          req_op;
  logic               rsp_valid;
  logic               rsp_hit;
  logic [WAYW-1:0]    rsp_way;
  logic               rsp_evict;
  logic [TAG_W-1:0]   rsp_evict_tag;
  logic               flush_start;
  logic               flush_busy;

  modport master (
    output req_valid, req_addr, req_op, flush_start,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag, flush_busy
  );

  modport slave (
    input  req_valid, req_addr, req_op, flush_start,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag, flush_busy
  );

endinterface

// File: rtl/cache_tag_array_chk.sv
// Protocol and consistency checks for the tag store; simulation-only observers.
module cache_tag_array_chk #(
  parameter int WAYS = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  input logic            accept_i,
  input logic [WAYS-1:0] match_i,
  input logic            rsp_valid_i
);

  // Two ways holding the same valid tag means the fill path is broken.
  a_single_match: assert property (@(posedge clk_i) disable iff (rst_i) accept_i |-> $onehot0(match_i));

  a_rsp_latency: assert property (@(posedge clk_i) disable iff (rst_i) accept_i |=> rsp_valid_i);

endmodule

// File: rtl/cache_tag_array_victim_sel.sv
// Replacement choice for one set: lowest invalid way first, otherwise the round-robin pointer.
module cache_victim_sel #(
  parameter int WAYS = 2,
  parameter int WAYW = 1
) (
  input  logic [WAYS-1:0] valid_i,
  input  logic [WAYW-1:0] ptr_i,
  output logic [WAYW-1:0] victim_o,
  output logic            victim_valid_o,
  output logic [WAYW-1:0] ptr_next_o
);

  logic [WAYW-1:0] lowest_s;
  logic            any_inv_s;

  // Scan from the top so the lowest invalid way is the last one kept.
  always_comb begin
    lowest_s  = '0;
    any_inv_s = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      lowest_s  = !valid_i[w] ? WAYW'(w) : lowest_s;
      any_inv_s = any_inv_s | !valid_i[w];
    end
  end

  assign victim_o       = any_inv_s ? lowest_s : ptr_i;
  assign victim_valid_o = !any_inv_s;
  assign ptr_next_o     = any_inv_s ? ptr_i :
                          ((ptr_i == WAYW'(WAYS - 1)) ? '0 : ptr_i + WAYW'(1));

endmodule

// File: rtl/cache_tag_array.sv
// N-way set-associative tag store with lookup/fill/invalidate, 1-cycle registered response
// and a one-set-per-cycle valid clear sweep after reset and on flush.
module cache_tag_array
  import cache_tag_array_pkg::*;
#(
  parameter int MAX_MEM       = 32,
  parameter int CACHE_WIDTHE  = 5,
  parameter int CACHE_DEEPTHE = 7,
  parameter int WAYS          = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cache_tag_array_if.slave bus
);

  localparam int TAG_W = BASIC_TAG_WIDTH(MAX_MEM, CACHE_WIDTHE, CACHE_DEEPTHE);
  localparam int SETS  = CACHE_SETS(CACHE_DEEPTHE);
  localparam int WAYW  = WAY_WIDTH(WAYS);
  localparam logic [CACHE_DEEPTHE-1:0] LAST_SET = '1;

  tag_state_e               state_q, state_d;
  logic [CACHE_DEEPTHE-1:0] cnt_q, cnt_d;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYW-1:0]  ptr_q   [SETS];

  logic [CACHE_DEEPTHE-1:0] idx_s;
  logic [TAG_W-1:0]         tag_s;
  logic                     idle_s, sweep_s, accept_s;
  logic [WAYS-1:0]          match_s;
  logic                     hit_s;
  logic [WAYW-1:0]          hit_way_s;
  logic [WAYW-1:0]          victim_s, ptr_next_s;
  logic                     victim_valid_s;
  logic                     fill_wr_s, inval_wr_s;
  logic                     unused_s;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [WAYW-1:0]  rsp_way_q, rsp_way_d;
  logic             rsp_evict_q, rsp_evict_d;
  logic [TAG_W-1:0] rsp_evict_tag_q, rsp_evict_tag_d;

  assign idx_s    = bus.req_addr[CACHE_WIDTHE +: CACHE_DEEPTHE];
  assign tag_s    = bus.req_addr[MAX_MEM-1 -: TAG_W];
  assign unused_s = ^bus.req_addr[CACHE_WIDTHE-1:0];

  assign idle_s   = (state_q == TAG_ST_IDLE);
  assign sweep_s  = (state_q == TAG_ST_INIT) || (state_q == TAG_ST_FLUSH);
  // A flush request in IDLE takes priority over a same-cycle request.
  assign accept_s = bus.req_valid && idle_s && !bus.flush_start;

  assign bus.req_ready  = idle_s && !bus.flush_start;
  assign bus.flush_busy = !idle_s;

  // Tag compare across the addressed set; the lowest matching way is reported.
  always_comb begin
    match_s   = '0;
    hit_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match_s[w] = valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s);
      hit_way_s  = match_s[w] ? WAYW'(w) : hit_way_s;
    end
  end

  assign hit_s = |match_s;

  cache_victim_sel #(
    .WAYS (WAYS),
    .WAYW (WAYW)
  ) u_victim_sel (
    .valid_i        (valid_q[idx_s]),
    .ptr_i          (ptr_q[idx_s]),
    .victim_o       (victim_s),
    .victim_valid_o (victim_valid_s),
    .ptr_next_o     (ptr_next_s)
  );

  assign fill_wr_s  = accept_s && (bus.req_op == CACHE_FILL) && !hit_s;
  assign inval_wr_s = accept_s && (bus.req_op == CACHE_INVAL) && hit_s;

  // Sweep sequencing: INIT and FLUSH walk every set once, IDLE waits for a flush request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      TAG_ST_INIT, TAG_ST_FLUSH: begin
        cnt_d = cnt_q + CACHE_DEEPTHE'(1);
        if (cnt_q == LAST_SET) begin
          state_d = TAG_ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      TAG_ST_IDLE: begin
        cnt_d = '0;
        if (bus.flush_start) begin
          state_d = TAG_ST_FLUSH;
        end else begin
          state_d = TAG_ST_IDLE;
        end
      end
      default: begin
        state_d = TAG_ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Sweep state and set counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TAG_ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response fields reflect the array as it was before this request's update.
  always_comb begin
    rsp_valid_d     = 1'b0;
    rsp_hit_d       = 1'b0;
    rsp_way_d       = '0;
    rsp_evict_d     = 1'b0;
    rsp_evict_tag_d = '0;
    if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_hit_d   = hit_s;
      case (bus.req_op)
        CACHE_FILL: begin
          if (hit_s) begin
            rsp_way_d = hit_way_s;
          end else begin
            rsp_way_d       = victim_s;
            rsp_evict_d     = victim_valid_s;
            rsp_evict_tag_d = victim_valid_s ? tag_q[idx_s][victim_s] : '0;
          end
        end
        default: begin
          rsp_way_d = hit_s ? hit_way_s : '0;
        end
      endcase
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  // Registered response; reset drops any pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_way_q       <= '0;
      rsp_evict_q     <= 1'b0;
      rsp_evict_tag_q <= '0;
    end else begin
      rsp_valid_q     <= rsp_valid_d;
      rsp_hit_q       <= rsp_hit_d;
      rsp_way_q       <= rsp_way_d;
      rsp_evict_q     <= rsp_evict_d;
      rsp_evict_tag_q <= rsp_evict_tag_d;
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_hit       = rsp_hit_q;
  assign bus.rsp_way       = rsp_way_q;
  assign bus.rsp_evict     = rsp_evict_q;
  assign bus.rsp_evict_tag = rsp_evict_tag_q;

  // Valid bits and round-robin pointers; valid bits are left to the sweep rather than reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
      end
    end else if (sweep_s) begin
      valid_q[cnt_q] <= '0;
    end else if (fill_wr_s) begin
      valid_q[idx_s][victim_s] <= 1'b1;
      ptr_q[idx_s]             <= ptr_next_s;
    end else if (inval_wr_s) begin
      valid_q[idx_s][hit_way_s] <= 1'b0;
    end
  end

  // Tag storage is written only on a fill miss.
  always_ff @(posedge clk_i) begin
    if (fill_wr_s && !rst_i) begin
      tag_q[idx_s][victim_s] <= tag_s;
    end
  end

  cache_tag_array_chk #(
    .WAYS (WAYS)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .accept_i    (accept_s),
    .match_i     (match_s),
    .rsp_valid_i (rsp_valid_q)
  );

endmodule

// File: tb/tb_cache_tag_array.sv
// Randomised scoreboard bench for cache_tag_array against a set/way reference model.
module tb_cache_tag_array;
  import cache_tag_array_pkg::*;

  localparam int MAX_MEM = 32;
  localparam int WIDTHE  = 5;
  localparam int DEEPTHE = 7;
  localparam int WAYS    = 2;
  localparam int TAG_W   = 20;
  localparam int WAYW    = 1;
  localparam int SETS    = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_tag_array_if #(.MAX_MEM(MAX_MEM), .TAG_W(TAG_W), .WAYW(WAYW)) bus ();

  cache_tag_array #(
    .MAX_MEM(MAX_MEM), .CACHE_WIDTHE(WIDTHE), .CACHE_DEEPTHE(DEEPTHE), .WAYS(WAYS)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic             hit;
    logic [WAYW-1:0]  way;
    logic             evict;
    logic [TAG_W-1:0] etag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  bit               m_valid [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  int               m_ptr   [SETS];

  logic [TAG_W-1:0] tag_pool [6] = '{20'h00001, 20'h00002, 20'h00003, 20'h00004, 20'h00005, 20'hABCDE};
  int               idx_pool [4] = '{2, 5, 0, 127};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [TAG_W-1:0] tg, input int idx);
    logic [6:0] i7;
    i7 = idx[6:0];
    return {tg, i7, 5'd0};
  endfunction

  task automatic model_clear(input bit reset_ptrs);
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      if (reset_ptrs) m_ptr[s] = 0;
    end
  endtask

  // Reference behaviour: compute response from the pre-op state, then apply the op.
  task automatic model(input logic [31:0] addr, input cache_op_e op);
    int idx, hw, vic;
    logic [TAG_W-1:0] tg;
    exp_t e;
    idx = int'(addr[11:5]);
    tg  = addr[31:12];
    e.hit = 1'b0; e.way = '0; e.evict = 1'b0; e.etag = '0;
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && m_valid[idx][w] && m_tag[idx][w] == tg) hw = w;
    e.hit = (hw >= 0);
    if (hw >= 0) e.way = WAYW'(hw);
    if (op == CACHE_FILL && hw < 0) begin
      vic = -1;
      for (int w = 0; w < WAYS; w++)
        if (vic < 0 && !m_valid[idx][w]) vic = w;
      if (vic < 0) begin
        vic        = m_ptr[idx];
        e.evict    = 1'b1;
        e.etag     = m_tag[idx][vic];
        m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
      end
      m_valid[idx][vic] = 1'b1;
      m_tag[idx][vic]   = tg;
      e.way             = WAYW'(vic);
    end else if (op == CACHE_INVAL && hw >= 0) begin
      m_valid[idx][hw] = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic issue(input logic [31:0] addr, input cache_op_e op);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_op    = op;
    #1;
    check("req_ready", {31'd0, bus.req_ready}, 32'd1);
    model(addr, op);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 1000 && bus.flush_busy === 1'b1; i++) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Scoreboard monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_hit",       {31'd0, bus.rsp_hit},       {31'd0, mon_e.hit});
        check("rsp_way",       {31'd0, bus.rsp_way},       {31'd0, mon_e.way});
        check("rsp_evict",     {31'd0, bus.rsp_evict},     {31'd0, mon_e.evict});
        check("rsp_evict_tag", {12'd0, bus.rsp_evict_tag}, {12'd0, mon_e.etag});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int op_r;
    cache_op_e op;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_op      = CACHE_LOOKUP;
    bus.flush_start = 1'b0;
    model_clear(1'b1);

    @(negedge clk);
    check("reset_ready",     {31'd0, bus.req_ready},     32'd0);
    check("reset_busy",      {31'd0, bus.flush_busy},    32'd1);
    check("reset_rsp_valid", {31'd0, bus.rsp_valid},     32'd0);
    check("reset_rsp_hit",   {31'd0, bus.rsp_hit},       32'd0);
    check("reset_rsp_way",   {31'd0, bus.rsp_way},       32'd0);
    check("reset_evict",     {31'd0, bus.rsp_evict},     32'd0);
    check("reset_evict_tag", {12'd0, bus.rsp_evict_tag}, 32'd0);
    rst = 1'b0;
    count_busy(n);
    check("init_cycles", n, 128);

    issue(32'h1040, CACHE_LOOKUP);
    issue(32'h1040, CACHE_FILL);
    issue(32'h1040, CACHE_LOOKUP);
    issue(32'h1040, CACHE_FILL);
    issue(32'h2040, CACHE_FILL);
    issue(32'h3040, CACHE_FILL);
    issue(32'h1040, CACHE_LOOKUP);
    issue(32'h2040, CACHE_LOOKUP);
    issue(32'h2040, CACHE_INVAL);
    issue(32'h2040, CACHE_LOOKUP);
    issue(32'h5040, CACHE_INVAL);
    issue(32'h3040, CACHE_LOOKUP);
    issue(32'h305f, CACHE_RSVD);
    idle();
    idle();

    // Flush and request in the same cycle: request must be refused.
    bus.flush_start = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_addr    = 32'h3040;
    bus.req_op      = CACHE_LOOKUP;
    #1;
    check("flush_blocks_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    bus.flush_start = 1'b0;
    bus.req_valid   = 1'b0;
    check("flush_req_dropped", {31'd0, bus.rsp_valid}, 32'd0);
    count_busy(n);
    check("flush_cycles", n, 128);
    model_clear(1'b0);
    issue(32'h3040, CACHE_LOOKUP);
    issue(32'h1040, CACHE_LOOKUP);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3, 0) != 0) begin
        op_r = $urandom_range(9, 0);
        op = (op_r < 4) ? CACHE_FILL : (op_r < 7) ? CACHE_LOOKUP : (op_r < 9) ? CACHE_INVAL : CACHE_RSVD;
        issue(mk(tag_pool[$urandom_range(5, 0)], idx_pool[$urandom_range(3, 0)]) | 32'($urandom_range(31, 0)), op);
      end else begin
        idle();
      end
    end

    // Leave set 9 with its pointer at way 1 so a reset of the pointers is visible later.
    issue(mk(20'h00011, 9), CACHE_FILL);
    issue(mk(20'h00012, 9), CACHE_FILL);
    issue(mk(20'h00013, 9), CACHE_FILL);
    idle();

    bus.flush_start = 1'b1;
    @(negedge clk);
    bus.flush_start = 1'b0;
    for (int i = 0; i < 40; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_flush_rsp_valid", {31'd0, bus.rsp_valid},  32'd0);
    check("rst_mid_flush_busy",      {31'd0, bus.flush_busy}, 32'd1);
    rst = 1'b0;
    model_clear(1'b1);
    n = 0;
    for (int i = 0; i < 1000 && bus.flush_busy === 1'b1; i++) begin
      bus.flush_start = (n == 50);
      n++;
      @(negedge clk);
    end
    bus.flush_start = 1'b0;
    check("reinit_cycles", n, 128);
    check("ready_after_init", {31'd0, bus.req_ready}, 32'd1);

    issue(mk(20'h00013, 9), CACHE_LOOKUP);
    issue(mk(20'h00021, 9), CACHE_FILL);
    issue(mk(20'h00022, 9), CACHE_FILL);
    issue(mk(20'h00023, 9), CACHE_FILL);
    issue(mk(20'h00022, 9), CACHE_LOOKUP);
    idle();
    idle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
